// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - hazard, memory-wait and flush sequencer for the 5-stage pipeline
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT  = 64,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en,
    input  logic [4:0]       id_rsAddr,
    input  logic [4:0]       id_rtAddr,
    input  logic             id_usesRs,
    input  logic             id_usesRt,
    input  logic [4:0]       ex_registerWriteAddress,
    input  logic             ex_ifWriteRegsFile,
    input  logic             ex_memOutOrAluOutWriteBackToRegFile,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             except_req,
    input  logic             eret_req,
    output logic             id_shouldStall,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             pipe_en,
    output logic             exceptClear,
    output logic             eret_clearSignal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W  = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t             state;
    logic [WAIT_W-1:0]  waitCnt;
    logic [FLUSH_W-1:0] flushCnt;

    logic active;
    logic loadUse;
    logic stallBubble;
    logic holdFront;
    logic memStall;
    logic exClr;
    logic erClr;
    logic timeoutHit;

    // Reset and cpu_en both mask every decision so nothing fires while frozen.
    assign active  = cpu_en & rst;
    assign loadUse = ex_memOutOrAluOutWriteBackToRegFile & ex_ifWriteRegsFile
                   & (ex_registerWriteAddress != 5'd0)
                   & ((id_usesRs & (id_rsAddr == ex_registerWriteAddress))
                    | (id_usesRt & (id_rtAddr == ex_registerWriteAddress)));

    always_comb begin
        stallBubble = 1'b0;
        holdFront   = 1'b0;
        memStall    = 1'b0;
        exClr       = 1'b0;
        erClr       = 1'b0;
        timeoutHit  = 1'b0;
        if (active) begin
            case (state)
                RUN: begin
                    if (except_req) begin
                        exClr = 1'b1;
                    end else if (eret_req) begin
                        erClr = 1'b1;
                    end else if (mem_req && !mem_ready) begin
                        memStall  = 1'b1;
                        holdFront = 1'b1;
                    end else if (loadUse) begin
                        stallBubble = 1'b1;
                        holdFront   = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        memStall  = 1'b1;
                        holdFront = 1'b1;
                        if (waitCnt == WAIT_LAST) begin
                            timeoutHit = 1'b1;
                            exClr      = 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    stallBubble = 1'b1;
                    if (except_req) begin
                        exClr = 1'b1;
                    end else if (eret_req) begin
                        erClr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign id_shouldStall   = stallBubble;
    assign pc_hold          = holdFront;
    assign ifid_hold        = holdFront;
    assign pipe_en          = cpu_en & ~memStall;
    assign exceptClear      = exClr;
    assign eret_clearSignal = erClr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            waitCnt      <= '0;
            flushCnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else if (cpu_en) begin
            if ((stallBubble || memStall || holdFront) && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            case (state)
                RUN: begin
                    if (exClr || erClr) begin
                        state    <= FLUSH;
                        flushCnt <= FLUSH_LOAD;
                    end else if (memStall) begin
                        state   <= MEM_WAIT;
                        waitCnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (timeoutHit) begin
                        mem_timeout <= 1'b1;
                        state       <= FLUSH;
                        flushCnt    <= FLUSH_LOAD;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (exClr || erClr) begin
                        flushCnt <= FLUSH_LOAD;
                    end else if (flushCnt <= FLUSH_W'(1)) begin
                        flushCnt <= '0;
                        state    <= RUN;
                    end else begin
                        flushCnt <= flushCnt - 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - vector table and corner-case sequences for pipeline_stall_controller
module tb_pipeline_stall_controller;

    logic       clk;
    logic       rst;
    logic       cpu_en;
    logic [4:0] id_rsAddr;
    logic [4:0] id_rtAddr;
    logic       id_usesRs;
    logic       id_usesRt;
    logic [4:0] ex_registerWriteAddress;
    logic       ex_ifWriteRegsFile;
    logic       ex_memOutOrAluOutWriteBackToRegFile;
    logic       mem_req;
    logic       mem_ready;
    logic       except_req;
    logic       eret_req;

    logic        aStall, aPcHold, aIfidHold, aPipeEn, aExc, aEret, aTimeout;
    logic [15:0] aCycles;
    logic        bStall, bPcHold, bIfidHold, bPipeEn, bExc, bEret, bTimeout;
    logic [3:0]  bCycles;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       cpuEn;
        logic       exc;
        logic       eret;
        logic       memReq;
        logic       memReady;
        int         hz;
        logic [5:0] exp;
        int         cnt;
    } vec_t;

    typedef struct {
        logic [5:0] exp;
        int         cnt;
        int         idx;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];

    pipeline_stall_controller #(.MEM_TIMEOUT(64), .FLUSH_CYCLES(2), .CNT_W(16)) uA (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .id_rsAddr(id_rsAddr), .id_rtAddr(id_rtAddr),
        .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
        .ex_registerWriteAddress(ex_registerWriteAddress),
        .ex_ifWriteRegsFile(ex_ifWriteRegsFile),
        .ex_memOutOrAluOutWriteBackToRegFile(ex_memOutOrAluOutWriteBackToRegFile),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .except_req(except_req), .eret_req(eret_req),
        .id_shouldStall(aStall), .pc_hold(aPcHold), .ifid_hold(aIfidHold),
        .pipe_en(aPipeEn), .exceptClear(aExc), .eret_clearSignal(aEret),
        .mem_timeout(aTimeout), .stall_cycles(aCycles)
    );

    pipeline_stall_controller #(.MEM_TIMEOUT(4), .FLUSH_CYCLES(1), .CNT_W(4)) uB (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .id_rsAddr(id_rsAddr), .id_rtAddr(id_rtAddr),
        .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
        .ex_registerWriteAddress(ex_registerWriteAddress),
        .ex_ifWriteRegsFile(ex_ifWriteRegsFile),
        .ex_memOutOrAluOutWriteBackToRegFile(ex_memOutOrAluOutWriteBackToRegFile),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .except_req(except_req), .eret_req(eret_req),
        .id_shouldStall(bStall), .pc_hold(bPcHold), .ifid_hold(bIfidHold),
        .pipe_en(bPipeEn), .exceptClear(bExc), .eret_clearSignal(bEret),
        .mem_timeout(bTimeout), .stall_cycles(bCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // 0: EX not a load, 1: load-use on rs, 2: load to $0, 3: load-use on rt
    task automatic setHz(input int h);
        id_usesRs = 1'b1;
        id_usesRt = 1'b0;
        id_rtAddr = 5'd3;
        ex_ifWriteRegsFile = 1'b1;
        case (h)
            1: begin
                ex_memOutOrAluOutWriteBackToRegFile = 1'b1;
                ex_registerWriteAddress = 5'd5; id_rsAddr = 5'd5; id_usesRt = 1'b1;
            end
            2: begin
                ex_memOutOrAluOutWriteBackToRegFile = 1'b1;
                ex_registerWriteAddress = 5'd0; id_rsAddr = 5'd0;
            end
            3: begin
                ex_memOutOrAluOutWriteBackToRegFile = 1'b1;
                ex_registerWriteAddress = 5'd7; id_rsAddr = 5'd2;
                id_rtAddr = 5'd7; id_usesRt = 1'b1;
            end
            default: begin
                ex_memOutOrAluOutWriteBackToRegFile = 1'b0;
                ex_registerWriteAddress = 5'd5; id_rsAddr = 5'd5;
            end
        endcase
    endtask

    task automatic drive(input vec_t v);
        cpu_en     = v.cpuEn;
        except_req = v.exc;
        eret_req   = v.eret;
        mem_req    = v.memReq;
        mem_ready  = v.memReady;
        setHz(v.hz);
    endtask

    task automatic idle();
        cpu_en = 1'b1; except_req = 1'b0; eret_req = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        setHz(0);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // exp = {id_shouldStall, pc_hold, ifid_hold, pipe_en, exceptClear, eret_clearSignal}
    task automatic add(input logic c, input logic e, input logic r, input logic mq, input logic mr,
                       input int h, input logic [5:0] x, input int n);
        vec_t v;
        v.cpuEn = c; v.exc = e; v.eret = r; v.memReq = mq; v.memReady = mr;
        v.hz = h; v.exp = x; v.cnt = n;
        vecs.push_back(v);
    endtask

    initial begin
        sb_t sb;
        rst = 1'b0;
        idle();

        // reset with a pending memory stall and hazard: only pipe_en follows cpu_en
        mem_req = 1'b1;
        setHz(1);
        @(negedge clk);
        check("reset_outs", {aStall, aPcHold, aIfidHold, aPipeEn, aExc, aEret}, 6'b000100);
        check("reset_cycles", aCycles, 0);
        check("reset_timeout", aTimeout, 0);
        check("reset_b_outs", {bStall, bPcHold, bPipeEn, bExc}, 4'b0010);
        idle();
        @(posedge clk); #1 rst = 1'b1;

        add(1,0,0,0,0,0, 6'b000100, 0);
        add(1,0,0,0,0,1, 6'b111100, 0);
        add(1,0,0,0,0,0, 6'b000100, 1);
        add(1,0,0,0,0,2, 6'b000100, 1);
        add(1,0,0,0,0,3, 6'b111100, 1);
        add(1,0,0,0,0,0, 6'b000100, 2);
        add(1,0,0,1,0,0, 6'b011000, 2);
        add(1,0,0,1,0,0, 6'b011000, 3);
        add(1,0,0,1,0,0, 6'b011000, 4);
        add(1,0,0,1,0,0, 6'b011000, 5);
        add(1,0,0,1,0,0, 6'b011000, 6);
        add(1,0,0,1,1,0, 6'b000100, 7);
        add(1,0,0,1,1,0, 6'b000100, 7);
        add(1,1,1,0,0,1, 6'b000110, 7);
        add(1,0,0,0,0,0, 6'b100100, 7);
        add(1,0,0,0,0,0, 6'b100100, 8);
        add(1,0,0,0,0,0, 6'b000100, 9);
        add(1,0,1,0,0,0, 6'b000101, 9);
        add(0,0,0,0,0,0, 6'b000000, 9);
        add(0,0,0,0,0,0, 6'b000000, 9);
        add(0,1,0,0,0,0, 6'b000000, 9);
        add(1,0,0,0,0,0, 6'b100100, 9);
        add(1,0,0,0,0,0, 6'b100100, 10);
        add(1,0,0,0,0,0, 6'b000100, 11);
        add(1,0,1,0,0,0, 6'b000101, 11);
        add(1,1,0,0,0,0, 6'b100110, 11);
        add(1,0,0,0,0,0, 6'b100100, 12);
        add(1,0,0,0,0,0, 6'b100100, 13);
        add(1,0,0,0,0,0, 6'b000100, 14);
        add(1,0,1,1,0,0, 6'b000101, 14);
        add(1,0,0,0,0,0, 6'b100100, 14);
        add(1,0,0,0,0,0, 6'b100100, 15);
        add(1,0,0,1,0,1, 6'b011000, 16);
        add(1,1,0,1,0,0, 6'b011000, 17);
        add(1,0,0,1,1,0, 6'b000100, 18);
        add(1,0,0,0,0,0, 6'b000100, 18);
        add(0,0,0,0,0,1, 6'b000000, 18);
        add(1,0,0,0,0,0, 6'b000100, 18);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            sb.exp = vecs[i].exp; sb.cnt = vecs[i].cnt; sb.idx = i;
            sbq.push_back(sb);
            @(negedge clk);
            sb = sbq.pop_front();
            check($sformatf("vec%0d_outs", sb.idx),
                  {aStall, aPcHold, aIfidHold, aPipeEn, aExc, aEret}, sb.exp);
            check($sformatf("vec%0d_cycles", sb.idx), aCycles, sb.cnt);
        end
        check("table_timeout", aTimeout, 0);

        // reset asserted mid-MEM_WAIT after three wait cycles
        doReset();
        @(posedge clk); #1 mem_req = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        check("midwait_hold", aPcHold, 1);
        check("midwait_cycles", aCycles, 4);
        rst = 1'b0;
        #1;
        check("midwait_rst_outs", {aStall, aPcHold, aIfidHold, aPipeEn, aExc}, 5'b00010);
        check("midwait_rst_cycles", aCycles, 0);
        mem_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("after_rst_outs", {aStall, aPcHold, aPipeEn, aExc}, 4'b0010);
        check("after_rst_cycles", aCycles, 0);

        // memory timeout on the MEM_TIMEOUT=4 instance
        doReset();
        @(posedge clk); #1 mem_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("to_exc_c%0d", c), bExc, (c == 4) ? 1 : 0);
            check($sformatf("to_pipe_c%0d", c), bPipeEn, 0);
            check($sformatf("to_flag_c%0d", c), bTimeout, 0);
            @(posedge clk);
        end
        #1 mem_req = 1'b0;
        @(negedge clk);
        check("to_flush_stall", bStall, 1);
        check("to_flush_exc", bExc, 0);
        check("to_flag_set", bTimeout, 1);
        @(posedge clk);
        @(negedge clk);
        check("to_run_stall", bStall, 0);
        check("to_run_pipe", bPipeEn, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("to_flag_sticky", bTimeout, 1);

        // saturating counter: 20 load-use cycles
        doReset();
        @(posedge clk); #1 setHz(1);
        repeat (20) @(posedge clk);
        #1 setHz(0);
        check("sat_b_cycles", bCycles, 15);
        check("sat_a_cycles", aCycles, 20);
        @(negedge clk);
        check("sat_b_hold", bCycles, 15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
